// File: rtl/i_deser.sv
// rtl/i_deser.sv - parametrised serial-to-parallel input deserializer with bitslip and pattern alignment
//
// Captures D on posedge C (SDR) or on both edges of C (DDR) into a 2*WIDTH-bit
// history register. Every N = WIDTH/BPC enabled cycles a WIDTH-bit window of
// that history is presented on Q with a one-cycle DV strobe. The window offset
// can be moved one bit earlier per BITSLIP rising edge, or automatically until
// the emitted word equals ALIGN_PATTERN.
//
// Ports:
//   C        clock
//   R        asynchronous active-high reset
//   D        serial data in
//   E        enable; low freezes shifting, counting, FSM and Q
//   BITSLIP  manual slip request, rising-edge sensitive
//   ALIGN_EN enables automatic alignment to ALIGN_PATTERN
//   Q        parallel word, MSB is the earliest-received bit
//   DV       one-cycle strobe when Q updates
//   LOCKED   automatic alignment has seen ALIGN_PATTERN
module i_deser #(
    parameter int         WIDTH         = 8,
    parameter             DATA_RATE     = "DDR",
    parameter logic [9:0] ALIGN_PATTERN = 10'h05C
) (
    input  logic             C,
    input  logic             R,
    input  logic             D,
    input  logic             E,
    input  logic             BITSLIP,
    input  logic             ALIGN_EN,
    output logic [WIDTH-1:0] Q,
    output logic             DV,
    output logic             LOCKED
);

    localparam int BPC = (DATA_RATE == "SDR") ? 1 : 2;
    localparam int N   = WIDTH / BPC;
    localparam int SW  = 2 * WIDTH;
    localparam int CW  = $clog2(N);
    localparam int OW  = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [OW-1:0] OFS_LAST = OW'(WIDTH - 1);

    // FILL0/FILL1 are the two word periods needed to fill the history
    // register before the first word can be emitted.
    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL0,
        S_FILL1,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OW-1:0]    ofs_q, ofs_d;
    logic             slip_pend_q, slip_pend_d;
    logic             bs_q, bs_d;
    logic             locked_q, locked_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dv_q, dv_d;

    logic [SW-1:0]    sr_shift;
    logic [WIDTH-1:0] word;
    logic             bnd;
    logic             emit;
    logic             match;
    logic             auto_slip;

    // The bits that fall off the top of the history are never part of a
    // window (the largest offset reaches bit 2W-2 of the next value).
    logic unused_sr_top;
    assign unused_sr_top = ^sr_q[SW-1 -: BPC];

    generate
        if (BPC == 2) begin : g_ddr
            logic dneg_q;
            logic dneg_d;

            always_comb begin
                dneg_d = D;
            end

            // Falling-edge half of the DDR pair; it is the older of the two bits.
            always_ff @(negedge C or posedge R) begin
                if (R) begin
                    dneg_q <= 1'b0;
                end else begin
                    dneg_q <= dneg_d;
                end
            end

            assign sr_shift = {sr_q[SW-3:0], dneg_q, D};
        end else begin : g_sdr
            assign sr_shift = {sr_q[SW-2:0], D};
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        ofs_d       = ofs_q;
        q_d         = q_q;
        dv_d        = 1'b0;
        bs_d        = BITSLIP;
        emit        = 1'b0;
        auto_slip   = 1'b0;

        // The window is taken from the value being loaded on this edge, with
        // the offset in force before any slip applied on the same edge.
        word  = sr_shift[ofs_q +: WIDTH];
        match = (word == ALIGN_PATTERN[WIDTH-1:0]);
        bnd   = E && (cnt_q == CNT_LAST);

        if (E) begin
            sr_d  = sr_shift;
            cnt_d = bnd ? '0 : cnt_q + 1'b1;
            if (slip_pend_q) begin
                ofs_d = (ofs_q == OFS_LAST) ? '0 : ofs_q + 1'b1;
            end

            case (state_q)
                S_IDLE:  state_d = S_FILL0;
                S_FILL0: if (bnd) state_d = S_FILL1;
                S_FILL1: begin
                    if (bnd) begin
                        state_d = S_RUN;
                        emit    = 1'b1;
                    end
                end
                S_RUN:   emit = bnd;
                default: state_d = S_IDLE;
            endcase
        end

        if (emit) begin
            q_d = word;
        end
        dv_d = emit;

        // Once locked, mismatching data never triggers a new search.
        auto_slip = emit && ALIGN_EN && !locked_q && !match;
        locked_d  = ALIGN_EN && (locked_q || (emit && match));

        // A pending slip survives disabled cycles; manual and automatic
        // requests on the same edge merge into a single slip.
        slip_pend_d = (slip_pend_q && !E) || (BITSLIP && !bs_q) || auto_slip;
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            ofs_q       <= '0;
            slip_pend_q <= 1'b0;
            bs_q        <= 1'b0;
            locked_q    <= 1'b0;
            q_q         <= '0;
            dv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            ofs_q       <= ofs_d;
            slip_pend_q <= slip_pend_d;
            bs_q        <= bs_d;
            locked_q    <= locked_d;
            q_q         <= q_d;
            dv_q        <= dv_d;
        end
    end

    assign Q      = q_q;
    assign DV     = dv_q;
    assign LOCKED = locked_q;

endmodule

// File: tb/tb_i_deser.sv
// tb/tb_i_deser.sv - scoreboard testbench for i_deser, SDR and DDR instances side by side
module tb_i_deser;

    localparam int         W   = 8;
    localparam logic [9:0] PAT = 10'h05C;

    logic C        = 1'b0;
    logic R        = 1'b1;
    logic E        = 1'b0;
    logic BITSLIP  = 1'b0;
    logic ALIGN_EN = 1'b0;
    logic d_s      = 1'b0;
    logic d_d      = 1'b0;
    logic [W-1:0] q_s, q_d;
    logic         dv_s, dv_d, lk_s, lk_d;

    i_deser #(.WIDTH(W), .DATA_RATE("SDR"), .ALIGN_PATTERN(PAT)) u_sdr (
        .C(C), .R(R), .D(d_s), .E(E), .BITSLIP(BITSLIP), .ALIGN_EN(ALIGN_EN),
        .Q(q_s), .DV(dv_s), .LOCKED(lk_s)
    );

    i_deser #(.WIDTH(W), .DATA_RATE("DDR"), .ALIGN_PATTERN(PAT)) u_ddr (
        .C(C), .R(R), .D(d_d), .E(E), .BITSLIP(BITSLIP), .ALIGN_EN(ALIGN_EN),
        .Q(q_d), .DV(dv_d), .LOCKED(lk_d)
    );

    always #5 C = ~C;

    typedef struct {
        logic [W-1:0] word;
        time          t;
    } exp_t;

    exp_t         sbq_s[$];
    exp_t         sbq_d[$];
    bit           hist_s[$];
    bit           hist_d[$];
    int           ecnt[2];
    int           mofs[2];
    int           dvc[2];
    bit           mpend[2];
    bit           mlock[2];
    bit           bs_prev;
    logic [W-1:0] hold[2];
    bit           smode[2];
    logic [W-1:0] spat[2];
    int           sidx[2];
    int           n_cmp = 0;
    int           n_bad = 0;
    bit           al_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit next_bit(input int k);
        bit b;
        if (smode[k]) b = spat[k][W-1-(sidx[k] % W)];
        else          b = bit'($urandom_range(0, 1));
        sidx[k]++;
        return b;
    endfunction

    // Reference: keep every captured bit in arrival order; a word is the W bits
    // ending mofs bits before the newest, emitted every N-th enabled edge once
    // 2N enabled edges have passed.
    task automatic model_edge(input int k, input bit b0, input bit b1, input bit en,
                              input bit al, input bit rise);
        int           nper;
        int           h;
        logic [W-1:0] w;
        bit           auto_slip;
        bit           lock_set;
        exp_t         x;
        nper      = (k == 0) ? W : W / 2;
        auto_slip = 1'b0;
        lock_set  = 1'b0;
        if (en) begin
            if (k == 0) begin
                hist_s.push_back(b1);
            end else begin
                hist_d.push_back(b0);
                hist_d.push_back(b1);
            end
            ecnt[k]++;
            if (ecnt[k] >= 2 * nper && (ecnt[k] % nper) == 0) begin
                if (k == 0) h = hist_s.size();
                else        h = hist_d.size();
                for (int i = 0; i < W; i++) begin
                    if (k == 0) w[i] = hist_s[h-1-mofs[k]-i];
                    else        w[i] = hist_d[h-1-mofs[k]-i];
                end
                x.word = w;
                x.t    = $time + 1;
                if (k == 0) sbq_s.push_back(x);
                else        sbq_d.push_back(x);
                if (al && !mlock[k]) begin
                    if (w == PAT[W-1:0]) lock_set = 1'b1;
                    else                 auto_slip = 1'b1;
                end
            end
            if (mpend[k]) begin
                mofs[k]  = (mofs[k] + 1) % W;
                mpend[k] = 1'b0;
            end
        end
        if (rise || auto_slip) mpend[k] = 1'b1;
        if (!al)           mlock[k] = 1'b0;
        else if (lock_set) mlock[k] = 1'b1;
        while (hist_s.size() > 48) void'(hist_s.pop_front());
        while (hist_d.size() > 48) void'(hist_d.pop_front());
    endtask

    // Called at posedge+2; returns at the next posedge+2.
    task automatic cyc(input bit en, input bit bs, input bit al);
        bit s1, d0, d1, rise;
        E        = en;
        BITSLIP  = bs;
        ALIGN_EN = al;
        s1 = en ? next_bit(0) : bit'($urandom_range(0, 1));
        d0 = en ? next_bit(1) : bit'($urandom_range(0, 1));
        d1 = en ? next_bit(1) : bit'($urandom_range(0, 1));
        d_s = s1;
        d_d = d0;
        @(negedge C);
        #2;
        d_d = d1;
        @(posedge C);
        rise    = bs && !bs_prev;
        bs_prev = bs;
        model_edge(0, 1'b0, s1, en, al, rise);
        model_edge(1, d0, d1, en, al, rise);
        #1;
        chk("sdr_locked", lk_s, mlock[0]);
        chk("ddr_locked", lk_d, mlock[1]);
        #1;
    endtask

    task automatic do_reset();
        R       = 1'b1;
        E       = 1'b0;
        BITSLIP = 1'b0;
        #1;
        chk("sdr_rst_q", q_s, 0);
        chk("sdr_rst_dv", dv_s, 0);
        chk("sdr_rst_locked", lk_s, 0);
        chk("ddr_rst_q", q_d, 0);
        chk("ddr_rst_dv", dv_d, 0);
        chk("ddr_rst_locked", lk_d, 0);
        sbq_s.delete();
        sbq_d.delete();
        hist_s.delete();
        hist_d.delete();
        for (int k = 0; k < 2; k++) begin
            ecnt[k]  = 0;
            mofs[k]  = 0;
            mpend[k] = 1'b0;
            mlock[k] = 1'b0;
            hold[k]  = '0;
        end
        bs_prev = 1'b0;
        R = 1'b0;
        @(posedge C);
        #2;
    endtask

    task automatic mon(input int k, input logic [W-1:0] q, input logic dv);
        exp_t  x;
        bit    due;
        string nm;
        nm  = (k == 0) ? "sdr" : "ddr";
        due = 1'b0;
        if (k == 0) begin
            if (sbq_s.size() > 0 && sbq_s[0].t <= $time) begin
                x   = sbq_s.pop_front();
                due = 1'b1;
            end
        end else begin
            if (sbq_d.size() > 0 && sbq_d[0].t <= $time) begin
                x   = sbq_d.pop_front();
                due = 1'b1;
            end
        end
        if (dv === 1'b1) dvc[k]++;
        if (due) begin
            chk({nm, "_dv_due"}, dv, 1);
            chk({nm, "_q_word"}, q, x.word);
            hold[k] = x.word;
        end else begin
            chk({nm, "_dv_idle"}, dv, 0);
            chk({nm, "_q_hold"}, q, hold[k]);
        end
    endtask

    initial begin
        forever begin
            @(posedge C);
            #1;
            mon(0, q_s, dv_s);
            mon(1, q_d, dv_d);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            hold[k] = '0;
            dvc[k]  = 0;
            smode[k] = 1'b1;
            sidx[k] = 0;
        end
        al_r = 1'b0;
        @(posedge C);
        #2;
        do_reset();

        // Steady streams from reset: SDR 0xA5, DDR 0x3C.
        spat[0] = 8'hA5;
        spat[1] = 8'h3C;
        sidx[0] = 0;
        sidx[1] = 0;
        repeat (40) cyc(1, 0, 0);
        chk("sdr_q_a5", q_s, 8'hA5);
        chk("ddr_q_3c", q_d, 8'h3C);
        chk("sdr_dv_count", dvc[0], 4);
        chk("ddr_dv_count", dvc[1], 9);

        // Manual slip: one pulse, then seven more to wrap, then a held request.
        cyc(1, 1, 0);
        repeat (23) cyc(1, 0, 0);
        chk("sdr_slip1_d2", q_s, 8'hD2);
        chk("ddr_slip1_1e", q_d, 8'h1E);
        repeat (7) begin
            cyc(1, 1, 0);
            cyc(1, 0, 0);
        end
        repeat (24) cyc(1, 0, 0);
        chk("sdr_slip_wrap_a5", q_s, 8'hA5);
        chk("ddr_slip_wrap_3c", q_d, 8'h3C);
        repeat (10) cyc(1, 1, 0);
        repeat (24) cyc(1, 0, 0);
        chk("sdr_slip_held_d2", q_s, 8'hD2);
        chk("ddr_slip_held_1e", q_d, 8'h1E);

        // Enable gating mid-word.
        for (int g = 0; g < 8 && (ecnt[0] % 8) != 3; g++) cyc(1, 0, 0);
        repeat (5) cyc(0, 0, 0);
        repeat (20) cyc(1, 0, 0);
        chk("sdr_gate_d2", q_s, 8'hD2);
        chk("ddr_gate_1e", q_d, 8'h1E);

        // Reset right after a word boundary while DV is high.
        for (int g = 0; g < 40 && !(ecnt[0] >= 16 && (ecnt[0] % 8) == 0); g++) cyc(1, 0, 0);
        chk("sdr_dv_before_reset", dv_s, 1);
        do_reset();

        // Auto-align to 0x5C from an arbitrary bit phase.
        spat[0] = 8'h5C;
        spat[1] = 8'h5C;
        sidx[0] = $urandom_range(0, 7);
        sidx[1] = $urandom_range(1, 7);
        repeat (90) cyc(1, 0, 1);
        chk("sdr_align_locked", lk_s, 1);
        chk("ddr_align_locked", lk_d, 1);
        chk("sdr_align_q", q_s, 8'h5C);
        chk("ddr_align_q", q_d, 8'h5C);
        repeat (24) cyc(1, 0, 1);
        chk("sdr_align_stable", q_s, 8'h5C);
        chk("ddr_align_stable", q_d, 8'h5C);
        cyc(1, 0, 0);
        chk("sdr_unlock", lk_s, 0);
        chk("ddr_unlock", lk_d, 0);

        // Randomized data, enable, bitslip, align enable and occasional reset.
        smode[0] = 1'b0;
        smode[1] = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            if ($urandom_range(0, 39) == 0) al_r = !al_r;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, al_r);
        end
        repeat (3) cyc(1, 0, 0);
        chk("sdr_sb_drained", sbq_s.size(), 0);
        chk("ddr_sb_drained", sbq_d.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
